// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants, state encoding and edge-word layout for the Bellman-Ford controller
//
// Purpose: single home for the FSM state encoding, default sizes (node/edge/
// distance widths), the INF sentinel and the bit offsets of the {u,v,w}
// fields inside an edge-ROM word.
package bf_pkg;

  localparam int BF_NODES     = 32;
  localparam int BF_MAX_EDGES = 64;
  localparam int BF_DW        = 12;
  localparam int BF_NW        = 5;
  localparam int BF_EW        = 6;
  localparam int BF_INF       = (1 << (BF_DW - 1)) - 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    E_RD,
    U_RD,
    V_RD,
    CMP,
    WR,
    NEXT,
    CHECK,
    DONE
  } bf_state_e;

  // Largest positive value of a signed dw-bit distance; doubles as "unreached".
  function automatic int bf_inf(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Edge word is {u, v, w}: w in the low dw bits, v above it, u on top.
  function automatic int bf_w_lsb();
    return 0;
  endfunction

  function automatic int bf_v_lsb(input int dw);
    return dw;
  endfunction

  function automatic int bf_u_lsb(input int nw, input int dw);
    return nw + dw;
  endfunction

endpackage

// File: rtl/bf_relax_unit.sv
// rtl/bf_relax_unit.sv - combinational relax test and saturation-safe sum for one edge
//
// Purpose: decide whether edge (u,v,w) improves dist[v].
// Ports:
//   du_i    - dist[u], signed DW bits
//   dv_i    - dist[v], signed DW bits
//   w_i     - edge weight, signed DW bits
//   relax_o - 1 when du != INF, du+w < dv and du+w < INF
//   sum_o   - du+w truncated to DW bits (only meaningful when relax_o=1)
module bf_relax_unit
  import bf_pkg::*;
#(
  parameter int DW = BF_DW
) (
  input  logic [DW-1:0] du_i,
  input  logic [DW-1:0] dv_i,
  input  logic [DW-1:0] w_i,
  output logic          relax_o,
  output logic [DW-1:0] sum_o
);

  localparam logic [DW-1:0]        INF   = DW'(bf_inf(DW));
  localparam logic signed [DW:0]   INF_X = (DW + 1)'(bf_inf(DW));

  logic signed [DW:0] du_x;
  logic signed [DW:0] dv_x;
  logic signed [DW:0] w_x;
  logic signed [DW:0] sum_x;

  // One extra bit keeps du+w from wrapping, so the "< INF" test catches
  // sums that would overflow the stored width.
  always_comb begin
    du_x    = {du_i[DW-1], du_i};
    dv_x    = {dv_i[DW-1], dv_i};
    w_x     = {w_i[DW-1], w_i};
    sum_x   = du_x + w_x;
    relax_o = (du_i != INF) && (sum_x < dv_x) && (sum_x < INF_X);
    sum_o   = sum_x[DW-1:0];
  end

endmodule

// File: rtl/bf_relax_ctrl.sv
// rtl/bf_relax_ctrl.sv - Bellman-Ford shortest-path controller over external edge ROM and dist/pred RAMs
//
// Purpose: on start, initialise dist/pred for every node, then sweep the edge
// list relaxing edges until a pass makes no change or NODES-1 passes have run,
// followed by a write-free pass that flags a negative cycle.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start, src_node        - solve request (accepted in IDLE/DONE), source node
//   num_edges              - number of valid edges in the ROM
//   edge_addr / edge_data  - edge ROM read, data {u,v,w} one cycle later
//   dist_addr/we/wdata/rdata - distance RAM, 1-cycle read latency
//   pred_we/addr/wdata     - predecessor RAM write port
//   busy, done, neg_cycle, iter_count - status
module bf_relax_ctrl
  import bf_pkg::*;
#(
  parameter int NODES     = BF_NODES,
  parameter int MAX_EDGES = BF_MAX_EDGES,
  parameter int DW        = BF_DW,
  localparam int NW       = $clog2(NODES),
  localparam int EW       = $clog2(MAX_EDGES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NW-1:0]        src_node,
  input  logic [EW:0]          num_edges,
  output logic [EW-1:0]        edge_addr,
  input  logic [2*NW+DW-1:0]   edge_data,
  output logic [NW-1:0]        dist_addr,
  output logic                 dist_we,
  output logic [DW-1:0]        dist_wdata,
  input  logic [DW-1:0]        dist_rdata,
  output logic                 pred_we,
  output logic [NW-1:0]        pred_addr,
  output logic [NW-1:0]        pred_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 neg_cycle,
  output logic [NW-1:0]        iter_count
);

  localparam int W_LSB = bf_w_lsb();
  localparam int V_LSB = bf_v_lsb(DW);
  localparam int U_LSB = bf_u_lsb(NW, DW);
  localparam logic [DW-1:0] INF       = DW'(bf_inf(DW));
  localparam logic [NW-1:0] LAST_NODE = NW'(NODES - 1);

  bf_state_e     state_q, state_d;
  logic [NW-1:0] node_q, node_d;
  logic [EW-1:0] eidx_q, eidx_d;
  logic [NW-1:0] src_q, src_d;
  logic [EW:0]   ne_q, ne_d;
  logic [NW-1:0] u_q, u_d;
  logic [NW-1:0] v_q, v_d;
  logic [DW-1:0] w_q, w_d;
  logic [DW-1:0] du_q, du_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          chg_q, chg_d;   // current pass relaxed at least one edge
  logic          chk_q, chk_d;   // running the write-free negative-cycle pass
  logic          neg_q, neg_d;
  logic [NW-1:0] iter_q, iter_d;

  logic [NW-1:0] e_u, e_v;
  logic [DW-1:0] e_w;
  logic [EW:0]   eidx_nx;
  logic [NW-1:0] iter_nx;
  logic          relax;
  logic [DW-1:0] sum;

  assign e_u     = edge_data[U_LSB +: NW];
  assign e_v     = edge_data[V_LSB +: NW];
  assign e_w     = edge_data[W_LSB +: DW];
  assign eidx_nx = {1'b0, eidx_q} + {{EW{1'b0}}, 1'b1};
  assign iter_nx = iter_q + {{(NW-1){1'b0}}, 1'b1};

  // dist[v] arrives on dist_rdata during CMP and is consumed directly there.
  bf_relax_unit #(.DW(DW)) u_relax (
    .du_i    (du_q),
    .dv_i    (dist_rdata),
    .w_i     (w_q),
    .relax_o (relax),
    .sum_o   (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      node_q  <= '0;
      eidx_q  <= '0;
      src_q   <= '0;
      ne_q    <= '0;
      u_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      du_q    <= '0;
      sum_q   <= '0;
      chg_q   <= 1'b0;
      chk_q   <= 1'b0;
      neg_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      eidx_q  <= eidx_d;
      src_q   <= src_d;
      ne_q    <= ne_d;
      u_q     <= u_d;
      v_q     <= v_d;
      w_q     <= w_d;
      du_q    <= du_d;
      sum_q   <= sum_d;
      chg_q   <= chg_d;
      chk_q   <= chk_d;
      neg_q   <= neg_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    node_d     = node_q;
    eidx_d     = eidx_q;
    src_d      = src_q;
    ne_d       = ne_q;
    u_d        = u_q;
    v_d        = v_q;
    w_d        = w_q;
    du_d       = du_q;
    sum_d      = sum_q;
    chg_d      = chg_q;
    chk_d      = chk_q;
    neg_d      = neg_q;
    iter_d     = iter_q;
    edge_addr  = eidx_q;
    dist_addr  = '0;
    dist_we    = 1'b0;
    dist_wdata = '0;
    pred_we    = 1'b0;
    pred_addr  = '0;
    pred_wdata = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = INIT;
          node_d  = '0;
          eidx_d  = '0;
          src_d   = src_node;
          ne_d    = num_edges;
          iter_d  = '0;
          neg_d   = 1'b0;
          chg_d   = 1'b0;
          chk_d   = 1'b0;
        end
      end
      INIT: begin
        dist_addr  = node_q;
        dist_we    = 1'b1;
        dist_wdata = (node_q == src_q) ? '0 : INF;
        pred_we    = 1'b1;
        pred_addr  = node_q;
        pred_wdata = node_q;
        if (node_q == LAST_NODE) begin
          state_d = (ne_q == '0) ? DONE : E_RD;
        end else begin
          node_d = node_q + {{(NW-1){1'b0}}, 1'b1};
        end
      end
      E_RD: state_d = U_RD;
      U_RD: begin
        u_d       = e_u;
        v_d       = e_v;
        w_d       = e_w;
        dist_addr = e_u;
        state_d   = V_RD;
      end
      V_RD: begin
        du_d      = dist_rdata;
        dist_addr = v_q;
        state_d   = CMP;
      end
      CMP: begin
        sum_d = sum;
        if (relax) begin
          if (chk_q) begin
            neg_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WR;
          end
        end else begin
          state_d = NEXT;
        end
      end
      WR: begin
        dist_addr  = v_q;
        dist_we    = 1'b1;
        dist_wdata = sum_q;
        pred_we    = 1'b1;
        pred_addr  = v_q;
        pred_wdata = u_q;
        chg_d      = 1'b1;
        state_d    = NEXT;
      end
      NEXT: begin
        if (eidx_nx == ne_q) begin
          eidx_d = '0;
          if (chk_q) begin
            state_d = DONE;
          end else begin
            iter_d = iter_nx;
            chg_d  = 1'b0;
            if (!chg_q)                  state_d = DONE;
            else if (iter_nx == LAST_NODE) state_d = CHECK;
            else                         state_d = E_RD;
          end
        end else begin
          eidx_d  = eidx_nx[EW-1:0];
          state_d = E_RD;
        end
      end
      CHECK: begin
        chk_d   = 1'b1;
        state_d = E_RD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign neg_cycle  = neg_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_bf_relax_ctrl.sv
// tb/tb_bf_relax_ctrl.sv - directed self-checking bench for bf_relax_ctrl
module tb_bf_relax_ctrl;

  localparam int NODES     = 32;
  localparam int MAX_EDGES = 64;
  localparam int DW        = 12;
  localparam int NW        = 5;
  localparam int EW        = 6;
  localparam int INF       = 2047;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [NW-1:0]       src_node = '0;
  logic [EW:0]         num_edges = '0;
  logic [EW-1:0]       edge_addr;
  logic [2*NW+DW-1:0]  edge_data;
  logic [NW-1:0]       dist_addr;
  logic                dist_we;
  logic [DW-1:0]       dist_wdata;
  logic [DW-1:0]       dist_rdata;
  logic                pred_we;
  logic [NW-1:0]       pred_addr;
  logic [NW-1:0]       pred_wdata;
  logic                busy;
  logic                done;
  logic                neg_cycle;
  logic [NW-1:0]       iter_count;

  logic [2*NW+DW-1:0]  rom  [0:MAX_EDGES-1];
  logic [DW-1:0]       dmem [0:NODES-1];
  logic [NW-1:0]       pmem [0:NODES-1];
  int                  dist_wr_cnt = 0;
  int                  pred_wr_cnt = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bf_relax_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_node   (src_node),
    .num_edges  (num_edges),
    .edge_addr  (edge_addr),
    .edge_data  (edge_data),
    .dist_addr  (dist_addr),
    .dist_we    (dist_we),
    .dist_wdata (dist_wdata),
    .dist_rdata (dist_rdata),
    .pred_we    (pred_we),
    .pred_addr  (pred_addr),
    .pred_wdata (pred_wdata),
    .busy       (busy),
    .done       (done),
    .neg_cycle  (neg_cycle),
    .iter_count (iter_count)
  );

  // Memory models: synchronous read with 1-cycle latency, read-before-write.
  always @(posedge clk) begin
    edge_data  <= rom[edge_addr];
    dist_rdata <= dmem[dist_addr];
    if (dist_we) begin
      dmem[dist_addr] <= dist_wdata;
      dist_wr_cnt     <= dist_wr_cnt + 1;
    end
    if (pred_we) begin
      pmem[pred_addr] <= pred_wdata;
      pred_wr_cnt     <= pred_wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_edge(input int idx, input int u, input int v, input int w);
    logic [31:0] uu, vv, ww;
    uu = u; vv = v; ww = w;
    rom[idx] = {uu[NW-1:0], vv[NW-1:0], ww[DW-1:0]};
  endtask

  task automatic kick(input int src, input int ne);
    @(negedge clk);
    src_node  = NW'(src);
    num_edges = (EW + 1)'(ne);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    int dw0, pw0;
    logic [31:0] m2;

    m2 = 32'hFFFF_FFFE;
    for (int i = 0; i < MAX_EDGES; i++) rom[i] = '0;

    // Reset values
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_neg", {31'd0, neg_cycle}, 0);
    chk("rst_iter", {27'd0, iter_count}, 0);
    chk("rst_dwe", {31'd0, dist_we}, 0);
    chk("rst_pwe", {31'd0, pred_we}, 0);
    chk("rst_eaddr", {26'd0, edge_addr}, 0);
    chk("rst_daddr", {27'd0, dist_addr}, 0);
    chk("rst_paddr", {27'd0, pred_addr}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Chain 0->1(3)->2(4)
    set_edge(0, 0, 1, 3);
    set_edge(1, 1, 2, 4);
    kick(0, 2);
    chk("chain_busy", {31'd0, busy}, 1);
    wait_done("chain");
    chk("chain_d0", {20'd0, dmem[0]}, 0);
    chk("chain_d1", {20'd0, dmem[1]}, 3);
    chk("chain_d2", {20'd0, dmem[2]}, 7);
    chk("chain_d3", {20'd0, dmem[3]}, INF);
    chk("chain_p2", {27'd0, pmem[2]}, 1);
    chk("chain_p3", {27'd0, pmem[3]}, 3);
    chk("chain_iter", {27'd0, iter_count}, 2);
    chk("chain_neg", {31'd0, neg_cycle}, 0);
    chk("chain_busy_end", {31'd0, busy}, 0);

    // Negative edge
    set_edge(0, 0, 1, 5);
    set_edge(1, 0, 2, 2);
    set_edge(2, 2, 1, -4);
    kick(0, 3);
    chk("negw_done_clr", {31'd0, done}, 0);
    wait_done("negw");
    chk("negw_d1", {20'd0, dmem[1]}, {20'd0, m2[DW-1:0]});
    chk("negw_d2", {20'd0, dmem[2]}, 2);
    chk("negw_p1", {27'd0, pmem[1]}, 2);
    chk("negw_neg", {31'd0, neg_cycle}, 0);
    chk("negw_iter", {27'd0, iter_count}, 2);

    // Negative cycle
    set_edge(0, 1, 2, 1);
    set_edge(1, 2, 1, -3);
    set_edge(2, 0, 1, 0);
    kick(0, 3);
    wait_done("cyc");
    chk("cyc_neg", {31'd0, neg_cycle}, 1);
    chk("cyc_iter", {27'd0, iter_count}, NODES - 1);
    repeat (3) @(negedge clk);
    chk("cyc_hold_done", {31'd0, done}, 1);
    chk("cyc_hold_neg", {31'd0, neg_cycle}, 1);

    // No edges: DONE after NODES+1 cycles counted from the start cycle
    kick(7, 0);
    repeat (NODES - 1) @(negedge clk);
    chk("ne0_early", {31'd0, done}, 0);
    @(negedge clk);
    chk("ne0_done", {31'd0, done}, 1);
    chk("ne0_d7", {20'd0, dmem[7]}, 0);
    chk("ne0_d6", {20'd0, dmem[6]}, INF);
    chk("ne0_d0", {20'd0, dmem[0]}, INF);
    chk("ne0_p7", {27'd0, pmem[7]}, 7);
    chk("ne0_iter", {27'd0, iter_count}, 0);

    // Unreachable edge 5->6(1): only the INIT writes happen
    set_edge(0, 5, 6, 1);
    dw0 = dist_wr_cnt;
    pw0 = pred_wr_cnt;
    kick(0, 1);
    wait_done("unr");
    chk("unr_dwr", dist_wr_cnt - dw0, NODES);
    chk("unr_pwr", pred_wr_cnt - pw0, NODES);
    chk("unr_d6", {20'd0, dmem[6]}, INF);
    chk("unr_iter", {27'd0, iter_count}, 1);

    // Reset during WR of pass 3 on the cyclic graph
    set_edge(0, 1, 2, 1);
    set_edge(1, 2, 1, -3);
    set_edge(2, 0, 1, 0);
    kick(0, 3);
    n = 0;
    while (!(iter_count === 5'd2 && dist_we === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_found_wr", {31'd0, dist_we}, 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", {31'd0, busy}, 0);
    chk("mid_done", {31'd0, done}, 0);
    chk("mid_iter", {27'd0, iter_count}, 0);
    chk("mid_dwe", {31'd0, dist_we}, 0);
    chk("mid_pwe", {31'd0, pred_we}, 0);
    chk("mid_daddr", {27'd0, dist_addr}, 0);
    @(negedge clk);
    rst = 1'b0;

    // New solve: chain with src=1; a start pulse while busy must be ignored
    set_edge(0, 0, 1, 3);
    set_edge(1, 1, 2, 4);
    kick(1, 2);
    repeat (4) @(negedge clk);
    src_node  = 5'd0;
    num_edges = '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", {31'd0, busy}, 1);
    wait_done("re");
    chk("re_d0", {20'd0, dmem[0]}, INF);
    chk("re_d1", {20'd0, dmem[1]}, 0);
    chk("re_d2", {20'd0, dmem[2]}, 4);
    chk("re_p2", {27'd0, pmem[2]}, 1);
    chk("re_iter", {27'd0, iter_count}, 2);
    chk("re_neg", {31'd0, neg_cycle}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
